// File: rtl/frame_buf_writer.sv
// Frame-buffer writer: packs a PACK-pixel stream into memory words, one W x H raster per frame,
// then stalls the stream until the host acknowledges the completed buffer.
module frame_buf_writer #(
    parameter int unsigned W    = 256,
    parameter int unsigned H    = 256,
    parameter int unsigned DW   = 8,
    parameter int unsigned PACK = 4,
    parameter int unsigned AW   = 14
) (
    input  logic                 aclk,
    input  logic                 arst,
    input  logic [DW-1:0]        frame_stream_tdata,
    input  logic                 frame_stream_tvalid,
    output logic                 frame_stream_tready,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW*PACK-1:0]   mem_wdata,
    output logic                 frame_done,
    input  logic                 frame_ack,
    output logic [15:0]          frame_cnt
);

    localparam int unsigned NPIX = W * H;
    localparam int unsigned LW   = $clog2(PACK);
    localparam int unsigned PCW  = $clog2(NPIX);

    localparam logic [PCW-1:0] LastPix  = PCW'(NPIX - 1);
    localparam logic [LW-1:0]  LastLane = LW'(PACK - 1);

    typedef enum logic {StFill, StDone} state_e;

    state_e                  state_q;
    logic [PCW-1:0]          pix_cnt_q;
    logic [PACK-1:0][DW-1:0] asm_q;
    logic [PACK-1:0][DW-1:0] asm_d;
    logic [LW-1:0]           lane;
    logic                    hs;

    assign frame_stream_tready = (state_q == StFill);
    assign hs                  = frame_stream_tvalid & frame_stream_tready;
    assign lane                = pix_cnt_q[LW-1:0];

    // Assembled word including the byte arriving this cycle, so the final lane needs no extra stage.
    always_comb begin
        asm_d       = asm_q;
        asm_d[lane] = frame_stream_tdata;
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q    <= StFill;
            pix_cnt_q  <= '0;
            asm_q      <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            mem_we     <= 1'b0;
            frame_done <= 1'b0;
            if (hs) begin
                asm_q <= asm_d;
                if (lane == LastLane) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= AW'(pix_cnt_q >> LW);
                    mem_wdata <= asm_d;
                end
                if (pix_cnt_q == LastPix) begin
                    pix_cnt_q  <= '0;
                    state_q    <= StDone;
                    frame_done <= 1'b1;
                    frame_cnt  <= frame_cnt + 16'd1;
                end else begin
                    pix_cnt_q <= pix_cnt_q + PCW'(1);
                end
            end
            // Ack is only honoured once DONE is reached; an ack during FILL is dropped.
            if (state_q == StDone && frame_ack) begin
                state_q <= StFill;
            end
        end
    end

endmodule
